// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 panel scanner.
// Pixel words are {R,G,B} with R in the MSBs, each COLOUR_BITS wide.
package hub75_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_LATCH   = 2'd2,
      ST_DISPLAY = 2'd3
   } scan_state_t;

   localparam int DEF_PANEL_WIDTH = 64;
   localparam int DEF_SCAN_ROWS   = 16;
   localparam int DEF_COLOUR_BITS = 8;
   localparam int DEF_BASE_TIME   = 8;

   function automatic int red_lsb(input int colour_bits);
      return 2 * colour_bits;
   endfunction

   function automatic int green_lsb(input int colour_bits);
      return colour_bits;
   endfunction

   function automatic int blue_lsb(input int colour_bits);
      return 0;
   endfunction

endpackage

// File: rtl/hub75_scanner_if.sv
// Framebuffer read port between the scanner (master) and the pixel store (slave).
// Read data is expected one cycle after the address.
interface hub75_scanner_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 24
);
   logic [ADDR_W-1:0] fb_rd_addr;
   logic              fb_rd_buffer;
   logic [DATA_W-1:0] fb_rd_data_top;
   logic [DATA_W-1:0] fb_rd_data_bottom;

   modport master (
      output fb_rd_addr,
      output fb_rd_buffer,
      input  fb_rd_data_top,
      input  fb_rd_data_bottom
   );

   modport slave (
      input  fb_rd_addr,
      input  fb_rd_buffer,
      output fb_rd_data_top,
      output fb_rd_data_bottom
   );
endinterface

// File: rtl/hub75_bcm_timer.sv
// Binary-coded-modulation display window: BASE_TIME<<plane cycles long, OE active
// (low) for the first (window*brightness)>>8 cycles. Window and duty latch on load.
module hub75_bcm_timer
   import hub75_pkg::*;
#(
   parameter  int COLOUR_BITS = DEF_COLOUR_BITS,
   parameter  int BASE_TIME   = DEF_BASE_TIME,
   localparam int PLANE_W     = (COLOUR_BITS > 1) ? $clog2(COLOUR_BITS) : 1,
   localparam int TW          = $clog2(BASE_TIME) + COLOUR_BITS + 1
) (
   input  logic               pixel_clk,
   input  logic               reset,
   input  logic               load,
   input  logic               run,
   input  logic [PLANE_W-1:0] plane,
   input  logic [7:0]         brightness,
   output logic               oe,
   output logic               last
);

   logic [TW-1:0]   win_len;
   logic [TW-1:0]   on_len;
   logic [TW-1:0]   tick;
   logic [TW+7:0]   duty;

   always_comb begin
      duty = ({8'd0, TW'(BASE_TIME)} << plane) * {{TW{1'b0}}, brightness};
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         win_len <= '0;
         on_len  <= '0;
         tick    <= '0;
      end else if (load) begin
         win_len <= TW'(BASE_TIME) << plane;
         on_len  <= duty[TW+7:8];
         tick    <= '0;
      end else if (run) begin
         tick <= tick + 1'b1;
      end
   end

   assign oe   = !(run && (tick < on_len));
   assign last = run && (tick == win_len - 1'b1);

endmodule

// File: rtl/hub75_scanner.sv
// HUB75 row scanner: shifts one bit plane per row, latches it, then shows it for a
// binary-weighted window; double-buffered framebuffer swapped only at frame end.
module hub75_scanner
   import hub75_pkg::*;
#(
   parameter  int PANEL_WIDTH = DEF_PANEL_WIDTH,
   parameter  int SCAN_ROWS   = DEF_SCAN_ROWS,
   parameter  int COLOUR_BITS = DEF_COLOUR_BITS,
   parameter  int BASE_TIME   = DEF_BASE_TIME,
   localparam int ADDR_BITS   = $clog2(SCAN_ROWS),
   localparam int COL_BITS    = $clog2(PANEL_WIDTH)
) (
   input  logic                 pixel_clk,
   input  logic                 reset,
   output logic [1:0]           hub75_red,
   output logic [1:0]           hub75_green,
   output logic [1:0]           hub75_blue,
   output logic [ADDR_BITS-1:0] hub75_addr,
   output logic                 hub75_clk,
   output logic                 hub75_latch,
   output logic                 hub75_oe,
   hub75_scanner_if.master      fb,
   input  logic [7:0]           brightness,
   input  logic                 swap_req,
   output logic                 swap_ack,
   output logic                 frame_start
);

   localparam int PLANE_W = (COLOUR_BITS > 1) ? $clog2(COLOUR_BITS) : 1;
   localparam int CNT_W   = COL_BITS + 2;
   localparam int R_LSB   = red_lsb(COLOUR_BITS);
   localparam int G_LSB   = green_lsb(COLOUR_BITS);
   localparam int B_LSB   = blue_lsb(COLOUR_BITS);
   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(2 * PANEL_WIDTH + 1);
   localparam logic [CNT_W-1:0] PIX_LAST   = CNT_W'(2 * PANEL_WIDTH);

   scan_state_t          state, state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic [ADDR_BITS-1:0] row;
   logic [PLANE_W-1:0]   plane;
   logic                 buffer_q;
   logic                 pending;
   logic                 shift_done;
   logic                 disp_last;
   logic                 timer_oe;
   logic                 last_row;
   logic                 last_plane;
   logic                 load_pix;
   logic                 frame_end;

   assign shift_done = (state == ST_SHIFT) && (cnt == SHIFT_LAST);
   assign last_row   = (row == ADDR_BITS'(SCAN_ROWS - 1));
   assign last_plane = (plane == PLANE_W'(COLOUR_BITS - 1));
   assign frame_end  = (state == ST_DISPLAY) && disp_last && last_row && last_plane;
   // Read data for column c lands two cycles after its first address cycle.
   assign load_pix   = (state == ST_SHIFT) && (cnt != '0) && (cnt <= PIX_LAST);

   hub75_bcm_timer #(
      .COLOUR_BITS (COLOUR_BITS),
      .BASE_TIME   (BASE_TIME)
   ) u_bcm_timer (
      .pixel_clk  (pixel_clk),
      .reset      (reset),
      .load       (state == ST_LATCH),
      .run        (state == ST_DISPLAY),
      .plane      (plane),
      .brightness (brightness),
      .oe         (timer_oe),
      .last       (disp_last)
   );

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    state_nxt = ST_SHIFT;
         ST_SHIFT:   if (shift_done) state_nxt = ST_LATCH;
         ST_LATCH:   state_nxt = ST_DISPLAY;
         ST_DISPLAY: if (disp_last) state_nxt = ST_SHIFT;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         row   <= '0;
         plane <= '0;
      end else begin
         if ((state == ST_SHIFT) && !shift_done) cnt <= cnt + 1'b1;
         else                                    cnt <= '0;
         if ((state == ST_DISPLAY) && disp_last) begin
            if (last_plane) begin
               plane <= '0;
               row   <= last_row ? '0 : row + 1'b1;
            end else begin
               plane <= plane + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         hub75_red   <= '0;
         hub75_green <= '0;
         hub75_blue  <= '0;
         hub75_addr  <= '0;
         buffer_q    <= 1'b0;
         pending     <= 1'b0;
         swap_ack    <= 1'b0;
      end else begin
         if (load_pix) begin
            hub75_red   <= {fb.fb_rd_data_bottom[R_LSB + int'(plane)], fb.fb_rd_data_top[R_LSB + int'(plane)]};
            hub75_green <= {fb.fb_rd_data_bottom[G_LSB + int'(plane)], fb.fb_rd_data_top[G_LSB + int'(plane)]};
            hub75_blue  <= {fb.fb_rd_data_bottom[B_LSB + int'(plane)], fb.fb_rd_data_top[B_LSB + int'(plane)]};
         end
         // Row address moves on the LATCH edge, while OE is still high.
         if (shift_done) hub75_addr <= row;
         swap_ack <= 1'b0;
         if (frame_end && (pending || swap_req)) begin
            buffer_q <= ~buffer_q;
            pending  <= 1'b0;
            swap_ack <= 1'b1;
         end else if (swap_req) begin
            pending <= 1'b1;
         end
      end
   end

   always_comb begin
      hub75_clk      = (state == ST_SHIFT) && cnt[0] && (cnt >= CNT_W'(3));
      hub75_latch    = (state == ST_LATCH);
      hub75_oe       = (state == ST_DISPLAY) ? timer_oe : 1'b1;
      frame_start    = (state == ST_SHIFT) && (cnt == '0) && (row == '0) && (plane == '0);
      fb.fb_rd_addr  = '0;
      if (state == ST_SHIFT) fb.fb_rd_addr = {row, cnt[COL_BITS:1]};
   end

   assign fb.fb_rd_buffer = buffer_q;

endmodule

// File: tb/tb_hub75_scanner.sv
// Directed-plus-random bench for hub75_scanner; expected waveforms come from a
// per-frame arithmetic model of the scan, BCM and buffer-swap rules.
module tb_hub75_scanner;
   import hub75_pkg::*;

   localparam int PW = 4;
   localparam int SR = 2;
   localparam int CB = 2;
   localparam int BT = 4;
   localparam int AB = 1;
   localparam int COLB = 2;
   localparam int SHIFT_LEN = 2 * PW + 2;
   localparam int FRAME_LEN = SR * (CB * (SHIFT_LEN + 1) + BT * ((1 << CB) - 1));

   logic          pixel_clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    hub75_red, hub75_green, hub75_blue;
   logic [AB-1:0] hub75_addr;
   logic          hub75_clk, hub75_latch, hub75_oe;
   logic [7:0]    brightness = 8'd0;
   logic          swap_req = 1'b0;
   logic          swap_ack, frame_start;

   logic [3*CB-1:0] mem_top [0:15];
   logic [3*CB-1:0] mem_bot [0:15];

   int   checks = 0;
   int   errors = 0;
   logic m_buf  = 1'b0;
   logic m_pend = 1'b0;
   logic m_ack  = 1'b0;
   int   m_addr = 0;

   hub75_scanner_if #(.ADDR_W(AB + COLB), .DATA_W(3 * CB)) bus ();

   hub75_scanner #(
      .PANEL_WIDTH (PW),
      .SCAN_ROWS   (SR),
      .COLOUR_BITS (CB),
      .BASE_TIME   (BT)
   ) dut (
      .pixel_clk   (pixel_clk),
      .reset       (reset),
      .hub75_red   (hub75_red),
      .hub75_green (hub75_green),
      .hub75_blue  (hub75_blue),
      .hub75_addr  (hub75_addr),
      .hub75_clk   (hub75_clk),
      .hub75_latch (hub75_latch),
      .hub75_oe    (hub75_oe),
      .fb          (bus),
      .brightness  (brightness),
      .swap_req    (swap_req),
      .swap_ack    (swap_ack),
      .frame_start (frame_start)
   );

   always #5 pixel_clk = ~pixel_clk;

   always @(posedge pixel_clk) begin
      bus.fb_rd_data_top    <= mem_top[{bus.fb_rd_buffer, bus.fb_rd_addr}];
      bus.fb_rd_data_bottom <= mem_bot[{bus.fb_rd_buffer, bus.fb_rd_addr}];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge pixel_clk);
      #1;
   endtask

   function automatic int midx(input logic b, input int r, input int c);
      return int'(b) * 8 + r * PW + c;
   endfunction

   task automatic fill_mem();
      for (int i = 0; i < 16; i++) begin
         mem_top[i] = 6'($urandom);
         mem_bot[i] = 6'($urandom);
      end
   endtask

   // Per-cycle checks common to every state, then the swap rule and next swap_req.
   task automatic common(input int t, input int sw_a, input int sw_b);
      logic req;
      chk("fb_rd_buffer", bus.fb_rd_buffer, m_buf);
      chk("swap_ack", swap_ack, m_ack);
      chk("hub75_addr", hub75_addr, m_addr);
      req = (t == sw_a) || (t == sw_b);
      swap_req = req;
      m_ack = 1'b0;
      if ((t == FRAME_LEN - 1) && (m_pend || req)) begin
         m_buf  = ~m_buf;
         m_pend = 1'b0;
         m_ack  = 1'b1;
      end else if (req) begin
         m_pend = 1'b1;
      end
   endtask

   task automatic run_frame(input logic [7:0] br, input int sw_a, input int sw_b, input int abort_at);
      int t = 0;
      int w, on;
      logic [3*CB-1:0] pt, pb;
      brightness = br;
      for (int r = 0; r < SR; r++) begin
         for (int p = 0; p < CB; p++) begin
            for (int k = 0; k < SHIFT_LEN; k++) begin
               cyc();
               if (k < 2 * PW) chk("fb_rd_addr", bus.fb_rd_addr, r * PW + k / 2);
               chk("hub75_clk", hub75_clk, (k >= 3) && (k % 2 == 1));
               chk("frame_start", frame_start, t == 0);
               chk("oe_shift", hub75_oe, 1);
               chk("latch_shift", hub75_latch, 0);
               if (k >= 2) begin
                  pt = mem_top[midx(m_buf, r, (k - 2) / 2)];
                  pb = mem_bot[midx(m_buf, r, (k - 2) / 2)];
                  chk("red", hub75_red, {pb[2 * CB + p], pt[2 * CB + p]});
                  chk("green", hub75_green, {pb[CB + p], pt[CB + p]});
                  chk("blue", hub75_blue, {pb[p], pt[p]});
               end
               common(t, sw_a, sw_b);
               t++;
            end
            cyc();
            m_addr = r;
            chk("latch", hub75_latch, 1);
            chk("oe_latch", hub75_oe, 1);
            chk("clk_latch", hub75_clk, 0);
            common(t, sw_a, sw_b);
            t++;
            w  = BT << p;
            on = (w * int'(br)) / 256;
            for (int i = 0; i < w; i++) begin
               cyc();
               chk("oe_display", hub75_oe, (i < on) ? 0 : 1);
               chk("latch_display", hub75_latch, 0);
               chk("frame_start_display", frame_start, 0);
               if (t == abort_at) begin
                  reset = 1'b1;
                  #1;
                  chk("oe_on_reset", hub75_oe, 1);
                  chk("buffer_on_reset", bus.fb_rd_buffer, 0);
                  chk("addr_on_reset", bus.fb_rd_addr, 0);
                  chk("hub_addr_on_reset", hub75_addr, 0);
                  chk("red_on_reset", hub75_red, 0);
                  chk("ack_on_reset", swap_ack, 0);
                  swap_req = 1'b0;
                  m_buf = 1'b0;
                  m_pend = 1'b0;
                  m_ack = 1'b0;
                  m_addr = 0;
                  return;
               end
               common(t, sw_a, sw_b);
               t++;
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem_top[i] = '0;
         mem_bot[i] = '0;
      end
      mem_top[0] = 6'b10_00_00;

      cyc();
      cyc();
      chk("rst_oe", hub75_oe, 1);
      chk("rst_clk", hub75_clk, 0);
      chk("rst_latch", hub75_latch, 0);
      chk("rst_addr", hub75_addr, 0);
      chk("rst_fb_addr", bus.fb_rd_addr, 0);
      chk("rst_buffer", bus.fb_rd_buffer, 0);
      chk("rst_ack", swap_ack, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_colour", {hub75_red, hub75_green, hub75_blue}, 0);
      reset = 1'b0;

      // Single lit top pixel, nominal brightness, no swap.
      run_frame(8'd128, -1, -1, -1);
      // Random content, blanked, swap requested mid-frame.
      fill_mem();
      run_frame(8'd0, 20, -1, -1);
      // Full brightness, swap pending then requested again on the last cycle.
      fill_mem();
      run_frame(8'd255, 30, FRAME_LEN - 1, -1);
      // Swap arriving only on the final display cycle.
      run_frame(8'd128, FRAME_LEN - 1, -1, -1);
      for (int f = 0; f < 4; f++) begin
         fill_mem();
         run_frame(8'($urandom_range(0, 255)),
                   (f % 2 == 0) ? int'($urandom_range(0, FRAME_LEN - 1)) : -1,
                   int'($urandom_range(0, FRAME_LEN - 1)), -1);
      end
      // Reset while OE is active in the first display window.
      run_frame(8'd128, -1, -1, SHIFT_LEN + 1);
      cyc();
      reset = 1'b0;
      run_frame(8'd128, -1, -1, -1);
      fill_mem();
      run_frame(8'($urandom_range(0, 255)), 5, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
